// File: rtl/alu_issue.sv
`default_nettype none
// alu_issue: initiator side of the ALU start/done handshake, wrapping one
// operation at a time in valid/ready request/response channels; rev 1.0.
module alu_issue #(
  parameter int         WIDTH   = 16,
  parameter int         TIMEOUT = 31,
  parameter logic [7:0] MODE_LO = 8'h51,
  parameter logic [7:0] MODE_HI = 8'h54
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_ir,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error,
  output logic [3:0]       flags,
  output logic             alu_start,
  input  logic             alu_done,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_ir,
  output logic             alu_oe,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_aluout,
  input  logic             alu_carryout,
  input  logic             alu_overout,
  input  logic             alu_cmpo,
  input  logic             alu_enable_flags
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_RES  = 3'd3,
    WAIT_DONE = 3'd4,
    MODE      = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          armed;
  logic          is_mode;

  // armed keeps req_ready low while reset is applied even though the ALU is idle
  assign req_ready   = armed && (state == IDLE) && alu_done && !rsp_valid;
  assign alu_carryin = flags[1];
  assign is_mode     = (req_ir >= MODE_LO) && (req_ir <= MODE_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      armed      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      flags      <= 4'b0000;
      alu_start  <= 1'b0;
      alu_oe     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ir     <= 8'h00;
    end else begin
      armed     <= 1'b1;
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            alu_a  <= req_a;
            alu_b  <= req_b;
            alu_ir <= req_ir;
            if (is_mode) begin
              state <= MODE;
            end else begin
              state     <= ISSUE;
              alu_start <= 1'b1;
              alu_oe    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (timer == TLAST) begin
            alu_oe     <= 1'b0;
            alu_ir     <= 8'h00;
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
            if (!alu_done) state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // a result strobe on the final timeout cycle still counts as success
          if (alu_cmpo) begin
            rsp_result <= alu_aluout;
            rsp_error  <= 1'b0;
            if (alu_enable_flags)
              flags <= {alu_aluout[WIDTH-1], alu_overout, alu_carryout, alu_aluout == '0};
            if (alu_done) begin
              alu_oe    <= 1'b0;
              alu_ir    <= 8'h00;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= WAIT_DONE;
            end
          end else if (timer == TLAST) begin
            alu_oe     <= 1'b0;
            alu_ir     <= 8'h00;
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (alu_done) begin
            alu_oe    <= 1'b0;
            alu_ir    <= 8'h00;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        MODE: begin
          alu_ir     <= 8'h00;
          rsp_result <= '0;
          rsp_error  <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
